// File: rtl/elevator_request_scheduler_if.sv
// Request/status bundle between the elevator scheduler and the car datapath.
// The master drives requests; the slave (scheduler) drives status.
interface elevator_request_scheduler_if #(
    parameter int unsigned NUM_FLOORS = 51,
    parameter int unsigned FLOOR_W    = 6
);
    logic                  req_valid;
    logic [FLOOR_W-1:0]    requested_floor;
    logic                  req_ready;
    logic                  req_err;
    logic [FLOOR_W-1:0]    elevator_floor;
    logic [FLOOR_W-1:0]    target_floor;
    logic                  moving_up;
    logic                  moving_down;
    logic                  door_open;
    logic                  idle;
    logic [NUM_FLOORS-1:0] pending_mask;

    modport master (
        output req_valid, requested_floor,
        input  req_ready, req_err, elevator_floor, target_floor,
        input  moving_up, moving_down, door_open, idle, pending_mask
    );

    modport slave (
        input  req_valid, requested_floor,
        output req_ready, req_err, elevator_floor, target_floor,
        output moving_up, moving_down, door_open, idle, pending_mask
    );
endinterface

// File: rtl/elevator_request_scheduler.sv
// Single-car elevator scheduler: collects floor requests and serves them in SCAN order.
// Define EMERGENCY_STOP_EN to add the estop input and the HALT state.
module elevator_request_scheduler #(
    parameter int unsigned NUM_FLOORS  = 51,
    parameter int unsigned FLOOR_W     = 6,
    parameter int unsigned MOVE_CYCLES = 2,
    parameter int unsigned DOOR_CYCLES = 4
) (
    input logic clk,
    input logic reset,
`ifdef EMERGENCY_STOP_EN
    input logic estop,
`endif
    elevator_request_scheduler_if.slave bus
);
    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StMoveUp   = 3'd1;
    localparam logic [2:0] StMoveDown = 3'd2;
    localparam logic [2:0] StDoor     = 3'd3;
`ifdef EMERGENCY_STOP_EN
    localparam logic [2:0] StHalt     = 3'd4;
`endif

    localparam int unsigned MoveCntW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int unsigned DoorCntW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [MoveCntW-1:0] MoveLast = MoveCntW'(MOVE_CYCLES - 1);
    localparam logic [DoorCntW-1:0] DoorLast = DoorCntW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0]  TopFloor = FLOOR_W'(NUM_FLOORS - 1);

    logic [2:0]            state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic [FLOOR_W-1:0]    target_q, target_d;
    logic                  dir_q, dir_d;  // 1 = up
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [MoveCntW-1:0]   move_cnt_q, move_cnt_d;
    logic [DoorCntW-1:0]   door_cnt_q, door_cnt_d;
    logic                  req_err_q, req_err_d;
    logic                  moving_up_q, moving_up_d;
    logic                  moving_down_q, moving_down_d;
    logic                  door_open_q, door_open_d;
    logic                  idle_q, idle_d;
    logic                  req_ready_q, req_ready_d;

    logic                  accept;
    logic                  req_ok;
    logic                  door_reload;
    logic [FLOOR_W-1:0]    next_floor;

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0] fl);
        logic r;
        r = 1'b0;
        for (int f = 0; f < int'(NUM_FLOORS); f++) begin
            if (p[f] && (FLOOR_W'(f) > fl)) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0] fl);
        logic r;
        r = 1'b0;
        for (int f = 0; f < int'(NUM_FLOORS); f++) begin
            if (p[f] && (FLOOR_W'(f) < fl)) r = 1'b1;
        end
        return r;
    endfunction

    // Closest pending floor strictly ahead in the given direction, else the car floor.
    function automatic logic [FLOOR_W-1:0] nearest(input logic [NUM_FLOORS-1:0] p,
                                                   input logic [FLOOR_W-1:0] fl,
                                                   input logic up);
        logic [FLOOR_W-1:0] t;
        t = fl;
        if (up) begin
            for (int f = int'(NUM_FLOORS) - 1; f >= 0; f--) begin
                if (p[f] && (FLOOR_W'(f) > fl)) t = FLOOR_W'(f);
            end
        end else begin
            for (int f = 0; f < int'(NUM_FLOORS); f++) begin
                if (p[f] && (FLOOR_W'(f) < fl)) t = FLOOR_W'(f);
            end
        end
        return t;
    endfunction

    always_comb begin
        state_d     = state_q;
        floor_d     = floor_q;
        dir_d       = dir_q;
        pending_d   = pending_q;
        move_cnt_d  = move_cnt_q;
        door_cnt_d  = door_cnt_q;
        req_err_d   = 1'b0;
        door_reload = 1'b0;
        next_floor  = floor_q;
        accept      = bus.req_valid & req_ready_q;
        req_ok      = bus.requested_floor <= TopFloor;

        if (accept) begin
            if (!req_ok) begin
                req_err_d = 1'b1;
            end else if ((state_q == StDoor) && (bus.requested_floor == floor_q)) begin
                door_reload = 1'b1;
            end else begin
                pending_d[bus.requested_floor] = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                // Decided on registered pending only, so a new request takes one extra cycle.
                if (pending_q[floor_q]) begin
                    state_d            = StDoor;
                    pending_d[floor_q] = 1'b0;
                    door_cnt_d         = '0;
                end else if (any_above(pending_q, floor_q) &&
                             (dir_q || !any_below(pending_q, floor_q))) begin
                    state_d    = StMoveUp;
                    dir_d      = 1'b1;
                    move_cnt_d = '0;
                end else if (any_below(pending_q, floor_q)) begin
                    state_d    = StMoveDown;
                    dir_d      = 1'b0;
                    move_cnt_d = '0;
                end
            end
            StMoveUp, StMoveDown: begin
                if (move_cnt_q == MoveLast) begin
                    next_floor = (state_q == StMoveUp) ? floor_q + FLOOR_W'(1)
                                                       : floor_q - FLOOR_W'(1);
                    floor_d    = next_floor;
                    move_cnt_d = '0;
                    dir_d      = (state_q == StMoveUp);
                    // pending_d already holds a same-edge request for this floor: absorb it.
                    if (pending_d[next_floor]) begin
                        pending_d[next_floor] = 1'b0;
                        state_d               = StDoor;
                        door_cnt_d            = '0;
                    end else if ((state_q == StMoveUp) ? !any_above(pending_d, next_floor)
                                                       : !any_below(pending_d, next_floor)) begin
                        state_d = StIdle;
                    end
                end else begin
                    move_cnt_d = move_cnt_q + MoveCntW'(1);
                end
            end
            StDoor: begin
                if (door_reload) begin
                    door_cnt_d = '0;
                end else if (door_cnt_q != DoorLast) begin
                    door_cnt_d = door_cnt_q + DoorCntW'(1);
                end else begin
                    door_cnt_d = '0;
                    move_cnt_d = '0;
                    if (dir_q ? any_above(pending_d, floor_q) : any_below(pending_d, floor_q)) begin
                        state_d = dir_q ? StMoveUp : StMoveDown;
                    end else if (dir_q ? any_below(pending_d, floor_q)
                                       : any_above(pending_d, floor_q)) begin
                        state_d = dir_q ? StMoveDown : StMoveUp;
                        dir_d   = !dir_q;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
`ifdef EMERGENCY_STOP_EN
            StHalt: state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase

`ifdef EMERGENCY_STOP_EN
        if (estop) begin
            state_d    = StHalt;
            floor_d    = floor_q;
            pending_d  = '0;
            move_cnt_d = '0;
            door_cnt_d = '0;
        end
        req_ready_d = (state_d != StHalt);
`else
        req_ready_d = 1'b1;
`endif

        moving_up_d   = (state_d == StMoveUp);
        moving_down_d = (state_d == StMoveDown);
        door_open_d   = (state_d == StDoor);
        idle_d        = (state_d == StIdle) && (pending_d == '0);
        target_d      = nearest(pending_d, floor_d, dir_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            floor_q       <= '0;
            target_q      <= '0;
            dir_q         <= 1'b1;
            pending_q     <= '0;
            move_cnt_q    <= '0;
            door_cnt_q    <= '0;
            req_err_q     <= 1'b0;
            moving_up_q   <= 1'b0;
            moving_down_q <= 1'b0;
            door_open_q   <= 1'b0;
            idle_q        <= 1'b1;
            req_ready_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            floor_q       <= floor_d;
            target_q      <= target_d;
            dir_q         <= dir_d;
            pending_q     <= pending_d;
            move_cnt_q    <= move_cnt_d;
            door_cnt_q    <= door_cnt_d;
            req_err_q     <= req_err_d;
            moving_up_q   <= moving_up_d;
            moving_down_q <= moving_down_d;
            door_open_q   <= door_open_d;
            idle_q        <= idle_d;
            req_ready_q   <= req_ready_d;
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.req_err        = req_err_q;
    assign bus.elevator_floor = floor_q;
    assign bus.target_floor   = target_q;
    assign bus.moving_up      = moving_up_q;
    assign bus.moving_down    = moving_down_q;
    assign bus.door_open      = door_open_q;
    assign bus.idle           = idle_q;
    assign bus.pending_mask   = pending_q;
endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler (MOVE_CYCLES=2, DOOR_CYCLES=4).
module tb_elevator_request_scheduler;
    localparam int unsigned NF = 51;
    localparam int unsigned FW = 6;

    logic clk = 1'b0;
    logic reset;
`ifdef EMERGENCY_STOP_EN
    logic estop;
`endif

    elevator_request_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

    elevator_request_scheduler #(
        .NUM_FLOORS (NF),
        .FLOOR_W    (FW),
        .MOVE_CYCLES(2),
        .DOOR_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
`ifdef EMERGENCY_STOP_EN
        .estop(estop),
`endif
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rst, vld, flr;
        int e_floor, e_tgt, e_err, e_mu, e_md, e_door, e_idle, e_pend;
    } vec_t;

    vec_t vecs[15];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic vld, input int flr);
        bus.req_valid       = vld;
        bus.requested_floor = 6'(flr);
    endtask

    task automatic wait_door(input int exp_floor, input int exp_steps, input string name);
        int n = 0;
        while (!bus.door_open && n < 300) begin
            step();
            n++;
            chk({name, " mutex"},
                64'($onehot0({bus.moving_up, bus.moving_down, bus.door_open})), 64'd1);
        end
        chk({name, " steps"}, 64'(n), 64'(exp_steps));
        chk({name, " floor"}, 64'(bus.elevator_floor), 64'(exp_floor));
    endtask

    // Door already seen open for one cycle; it must stay three more, then close.
    task automatic door_hold(input int emu, input int emd, input int eidle, input int etgt,
                             input string name);
        for (int i = 0; i < 3; i++) begin
            step();
            chk({name, " open"}, 64'(bus.door_open), 64'd1);
        end
        step();
        chk({name, " closed"}, 64'(bus.door_open), 64'd0);
        chk({name, " mu"}, 64'(bus.moving_up), 64'(emu));
        chk({name, " md"}, 64'(bus.moving_down), 64'(emd));
        chk({name, " idle"}, 64'(bus.idle), 64'(eidle));
        chk({name, " target"}, 64'(bus.target_floor), 64'(etgt));
    endtask

    task automatic check_reset_state(input string name);
        chk({name, " floor"}, 64'(bus.elevator_floor), 64'd0);
        chk({name, " target"}, 64'(bus.target_floor), 64'd0);
        chk({name, " pend"}, 64'(bus.pending_mask), 64'd0);
        chk({name, " mu"}, 64'(bus.moving_up), 64'd0);
        chk({name, " md"}, 64'(bus.moving_down), 64'd0);
        chk({name, " door"}, 64'(bus.door_open), 64'd0);
        chk({name, " idle"}, 64'(bus.idle), 64'd1);
        chk({name, " ready"}, 64'(bus.req_ready), 64'd1);
        chk({name, " err"}, 64'(bus.req_err), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 0);
`ifdef EMERGENCY_STOP_EN
        estop = 1'b0;
`endif
        //          rst vld flr  floor tgt err mu md door idle pend
        vecs[0]  = '{1, 0, 0,    0,    0,  0,  0, 0, 0,   1,   0};
        vecs[1]  = '{0, 1, 55,   0,    0,  1,  0, 0, 0,   1,   0};
        vecs[2]  = '{0, 0, 0,    0,    0,  0,  0, 0, 0,   1,   0};
        vecs[3]  = '{0, 1, 51,   0,    0,  1,  0, 0, 0,   1,   0};
        vecs[4]  = '{0, 0, 0,    0,    0,  0,  0, 0, 0,   1,   0};
        vecs[5]  = '{0, 1, 63,   0,    0,  1,  0, 0, 0,   1,   0};
        vecs[6]  = '{0, 0, 0,    0,    0,  0,  0, 0, 0,   1,   0};
        vecs[7]  = '{0, 1, 0,    0,    0,  0,  0, 0, 0,   0,   1};
        vecs[8]  = '{0, 0, 0,    0,    0,  0,  0, 0, 1,   0,   0};
        vecs[9]  = '{0, 0, 0,    0,    0,  0,  0, 0, 1,   0,   0};
        vecs[10] = '{0, 1, 0,    0,    0,  0,  0, 0, 1,   0,   0};
        vecs[11] = '{0, 0, 0,    0,    0,  0,  0, 0, 1,   0,   0};
        vecs[12] = '{0, 0, 0,    0,    0,  0,  0, 0, 1,   0,   0};
        vecs[13] = '{0, 0, 0,    0,    0,  0,  0, 0, 1,   0,   0};
        vecs[14] = '{0, 0, 0,    0,    0,  0,  0, 0, 0,   1,   0};

        for (int i = 0; i < 15; i++) begin
            reset = 1'(vecs[i].rst);
            drive(1'(vecs[i].vld), vecs[i].flr);
            step();
            chk($sformatf("vec%0d floor", i), 64'(bus.elevator_floor), 64'(vecs[i].e_floor));
            chk($sformatf("vec%0d target", i), 64'(bus.target_floor), 64'(vecs[i].e_tgt));
            chk($sformatf("vec%0d err", i), 64'(bus.req_err), 64'(vecs[i].e_err));
            chk($sformatf("vec%0d mu", i), 64'(bus.moving_up), 64'(vecs[i].e_mu));
            chk($sformatf("vec%0d md", i), 64'(bus.moving_down), 64'(vecs[i].e_md));
            chk($sformatf("vec%0d door", i), 64'(bus.door_open), 64'(vecs[i].e_door));
            chk($sformatf("vec%0d idle", i), 64'(bus.idle), 64'(vecs[i].e_idle));
            chk($sformatf("vec%0d pend", i), 64'(bus.pending_mask), 64'(vecs[i].e_pend));
            chk($sformatf("vec%0d ready", i), 64'(bus.req_ready), 64'd1);
        end
        reset = 1'b0;
        drive(1'b0, 0);

        // Long run 0 -> 30.
        drive(1'b1, 30);
        step();
        drive(1'b0, 0);
        chk("s1 pend", 64'(bus.pending_mask), 64'd1 << 30);
        chk("s1 target", 64'(bus.target_floor), 64'd30);
        chk("s1 mu early", 64'(bus.moving_up), 64'd0);
        step();
        chk("s1 mu", 64'(bus.moving_up), 64'd1);
        wait_door(30, 60, "s1 arrive");
        chk("s1 pend cleared", 64'(bus.pending_mask), 64'd0);
        door_hold(0, 0, 1, 30, "s1 door");

        // Reset while moving down through floor 12.
        drive(1'b1, 0);
        step();
        drive(1'b0, 0);
        step();
        chk("s5 md", 64'(bus.moving_down), 64'd1);
        repeat (36) step();
        chk("s5 floor", 64'(bus.elevator_floor), 64'd12);
        chk("s5 md mid", 64'(bus.moving_down), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_state("s5 reset");

        // SCAN: heading to 30, pick up 20 ahead and 5 behind.
        drive(1'b1, 30);
        step();
        drive(1'b0, 0);
        step();
        chk("s3 mu", 64'(bus.moving_up), 64'd1);
        repeat (20) step();
        chk("s3 floor10", 64'(bus.elevator_floor), 64'd10);
        drive(1'b1, 20);
        step();
        drive(1'b1, 5);
        step();
        drive(1'b0, 0);
        chk("s3 pend", 64'(bus.pending_mask), (64'd1 << 30) | (64'd1 << 20) | (64'd1 << 5));
        chk("s3 target", 64'(bus.target_floor), 64'd20);
        chk("s3 floor11", 64'(bus.elevator_floor), 64'd11);
        wait_door(20, 18, "s3 stop20");
        door_hold(1, 0, 0, 30, "s3 door20");
        wait_door(30, 20, "s3 stop30");
        door_hold(0, 1, 0, 5, "s3 door30");
        wait_door(5, 50, "s3 stop5");
        door_hold(0, 0, 1, 5, "s3 door5");
        chk("s3 pend end", 64'(bus.pending_mask), 64'd0);

`ifdef EMERGENCY_STOP_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b1, 20);
        step();
        drive(1'b0, 0);
        step();
        repeat (14) step();
        chk("s6 floor7", 64'(bus.elevator_floor), 64'd7);
        estop = 1'b1;
        step();
        chk("s6 floor held", 64'(bus.elevator_floor), 64'd7);
        chk("s6 mu", 64'(bus.moving_up), 64'd0);
        chk("s6 door", 64'(bus.door_open), 64'd0);
        chk("s6 pend", 64'(bus.pending_mask), 64'd0);
        chk("s6 ready", 64'(bus.req_ready), 64'd0);
        drive(1'b1, 3);
        step();
        drive(1'b0, 0);
        chk("s6 no accept", 64'(bus.pending_mask), 64'd0);
        chk("s6 floor held2", 64'(bus.elevator_floor), 64'd7);
        estop = 1'b0;
        step();
        chk("s6 release ready", 64'(bus.req_ready), 64'd1);
        chk("s6 release idle", 64'(bus.idle), 64'd1);
        chk("s6 release floor", 64'(bus.elevator_floor), 64'd7);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
